// File: rtl/quadrature_decoder_pkg.sv
// Shared types and helpers for the quadrature decoder.
// Holds the AB state type, the four Gray-code states and the step classifier.
package qdec_pkg;

    typedef logic [1:0] ab_t;

    // AB states written as {A, B}
    localparam ab_t AB_00 = 2'b00;
    localparam ab_t AB_10 = 2'b10;
    localparam ab_t AB_11 = 2'b11;
    localparam ab_t AB_01 = 2'b01;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DOWN,
        STEP_ERR
    } step_t;

    // Successor of a state in the forward sequence 00 -> 10 -> 11 -> 01 -> 00
    function automatic ab_t next_fwd(input ab_t state);
        ab_t result;
        case (state)
            AB_00:   result = AB_10;
            AB_10:   result = AB_11;
            AB_11:   result = AB_01;
            default: result = AB_00;
        endcase
        return result;
    endfunction

    // Classifies a transition; both bits changing at once is an error
    function automatic step_t classify(input ab_t prev, input ab_t cur);
        step_t result;
        if (cur == prev) begin
            result = STEP_NONE;
        end else if (cur == next_fwd(prev)) begin
            result = STEP_UP;
        end else if (prev == next_fwd(cur)) begin
            result = STEP_DOWN;
        end else begin
            result = STEP_ERR;
        end
        return result;
    endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Counter-side bus of the quadrature decoder.
// The decoder drives it through the master modport; the up/down counter
// listens through the slave modport.
interface quadrature_decoder_if #(
    parameter int N = 4
);
    logic         enable;
    logic         upCount;
    logic         load;
    logic [N-1:0] loadValue;
    logic         errorTick;

    modport master (
        output enable,
        output upCount,
        output load,
        output loadValue,
        output errorTick
    );

    modport slave (
        input enable,
        input upCount,
        input load,
        input loadValue,
        input errorTick
    );
endinterface

// File: rtl/quadrature_decoder_input_filter.sv
// Synchroniser plus persistence filter for one asynchronous encoder input.
// A new level is accepted only after it has been seen for FILTER_LEN
// consecutive synchronised cycles.
module input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic filt_out
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic [CNT_W-1:0]       hold_count;
    logic                   synced;

    assign synced = sync_chain[SYNC_STAGES-1];

    // Shift the raw input through the metastability chain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
        end
    end

    // Count consecutive disagreeing cycles and accept the level on the last one
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_count <= '0;
            filt_out   <= 1'b0;
        end else if (synced == filt_out) begin
            hold_count <= '0;
        end else if (hold_count == CNT_W'(FILTER_LEN - 1)) begin
            hold_count <= '0;
            filt_out   <= synced;
        end else begin
            hold_count <= hold_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder front end for the generic up/down counter.
// Filters chA/chB/index, decodes direction, flags illegal AB jumps and
// issues index reloads. Build with QDEC_X4_EN for x4 decoding; without it
// only the 01<->00 edge counts (x1 decoding).
module quadrature_decoder
    import qdec_pkg::*;
#(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int INDEX_VALUE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    chA,
    input  logic                    chB,
    input  logic                    index,
    quadrature_decoder_if.master    bus
);

    logic  filt_a;
    logic  filt_b;
    logic  filt_idx;
    ab_t   cur_ab;
    ab_t   prev_ab;
    logic  primed;
    logic  idx_prev;
    step_t step_raw;
    step_t step_counted;
    logic  next_enable;
    logic  next_up;
    logic  next_load;
    logic  next_error;

    input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk(clk), .reset(reset), .async_in(chA), .filt_out(filt_a)
    );

    input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk(clk), .reset(reset), .async_in(chB), .filt_out(filt_b)
    );

    input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_idx (
        .clk(clk), .reset(reset), .async_in(index), .filt_out(filt_idx)
    );

    assign cur_ab        = {filt_a, filt_b};
    assign bus.loadValue = N'(INDEX_VALUE);

    // Decode the filtered AB change and index edge into next-cycle strobes
    always_comb begin
        step_raw     = STEP_NONE;
        step_counted = STEP_NONE;
        next_enable  = 1'b0;
        next_up      = 1'b0;
        next_load    = filt_idx & ~idx_prev;
        if (primed && (cur_ab != prev_ab)) begin
            step_raw = classify(prev_ab, cur_ab);
        end
`ifdef QDEC_X4_EN
        step_counted = step_raw;
`else
        if ((step_raw == STEP_UP) && (prev_ab == AB_01) && (cur_ab == AB_00)) begin
            step_counted = STEP_UP;
        end else if ((step_raw == STEP_DOWN) && (prev_ab == AB_00) && (cur_ab == AB_01)) begin
            step_counted = STEP_DOWN;
        end
`endif
        next_error = (step_raw == STEP_ERR);
        if (!next_load) begin
            next_enable = (step_counted == STEP_UP) || (step_counted == STEP_DOWN);
            next_up     = (step_counted == STEP_UP);
        end
    end

    // Track the last decoded AB state, the primed flag and the index level
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_ab  <= AB_00;
            primed   <= 1'b0;
            idx_prev <= 1'b0;
        end else begin
            idx_prev <= filt_idx;
            if (cur_ab != prev_ab) begin
                prev_ab <= cur_ab;
                primed  <= 1'b1;
            end
        end
    end

    // Register the one-cycle strobes toward the counter
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.enable    <= 1'b0;
            bus.upCount   <= 1'b0;
            bus.load      <= 1'b0;
            bus.errorTick <= 1'b0;
        end else begin
            bus.enable    <= next_enable;
            bus.upCount   <= next_up;
            bus.load      <= next_load;
            bus.errorTick <= next_error;
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder (N=4, SYNC_STAGES=2, FILTER_LEN=4).
// A cycle-level behavioural model predicts the strobes; directed scenarios
// also check pulse counts, latency and the resulting counter position.
module tb_quadrature_decoder;

    localparam int S  = 2;
    localparam int F  = 4;
    localparam int NW = 4;
`ifdef QDEC_X4_EN
    localparam bit X4 = 1'b1;
`else
    localparam bit X4 = 1'b0;
`endif

    typedef struct {
        bit a;
        bit b;
        bit i;
        int hold;
    } phase_t;

    logic clk;
    logic reset;
    logic chA;
    logic chB;
    logic index;

    quadrature_decoder_if #(.N(NW)) bus();

    quadrature_decoder #(.N(NW), .SYNC_STAGES(S), .FILTER_LEN(F), .INDEX_VALUE(0)) dut (
        .clk(clk),
        .reset(reset),
        .chA(chA),
        .chB(chB),
        .index(index),
        .bus(bus)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Behavioural model state
    bit       m_dly  [3][S];
    int       m_dn   [3];
    bit       m_win  [3][F];
    int       m_wn   [3];
    bit       m_filt [3];
    bit [1:0] m_prev;
    bit       m_primed;
    bit       m_idx_prev;
    bit [3:0] exp_out;

    // Observations of the DUT strobes
    int cnt_en, cnt_up, cnt_dn, cnt_load, cnt_err;
    int since_change;
    int last_lat;
    int pos_dut;

    function automatic bit [3:0] outs();
        return {bus.enable, bus.upCount, bus.load, bus.errorTick};
    endfunction

    function automatic int ring_pos(bit [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit counts(bit [1:0] p, bit [1:0] c, int d);
        if (X4) return 1'b1;
        return (d == 1 && p == 2'b01 && c == 2'b00) || (d == 3 && p == 2'b00 && c == 2'b01);
    endfunction

    task automatic clear_counts();
        cnt_en = 0; cnt_up = 0; cnt_dn = 0; cnt_load = 0; cnt_err = 0; last_lat = -1;
    endtask

    task automatic drive(input bit a, input bit b, input bit i);
        if ({a, b, i} != {chA, chB, index}) since_change = 0;
        chA = a; chB = b; index = i;
    endtask

    // One clock edge: update the model from sampled inputs, then observe the DUT
    task automatic tick();
        bit       raw [3];
        bit       syn;
        bit       all_new;
        bit [1:0] cur;
        bit       ld;
        int       d;
        @(posedge clk);
        raw[0] = chA; raw[1] = chB; raw[2] = index;
        if (reset) begin
            for (int j = 0; j < 3; j++) begin
                m_dn[j] = 0; m_wn[j] = 0; m_filt[j] = 1'b0;
            end
            m_prev = 2'b00; m_primed = 1'b0; m_idx_prev = 1'b0; exp_out = 4'b0000;
        end else begin
            exp_out = 4'b0000;
            cur = {m_filt[0], m_filt[1]};
            ld  = m_filt[2] && !m_idx_prev;
            if (cur != m_prev) begin
                if (m_primed) begin
                    d = (ring_pos(cur) - ring_pos(m_prev) + 4) % 4;
                    if (d == 2) exp_out[0] = 1'b1;
                    else if (!ld && counts(m_prev, cur, d)) begin
                        exp_out[3] = 1'b1;
                        exp_out[2] = (d == 1);
                    end
                end
                m_prev = cur; m_primed = 1'b1;
            end
            exp_out[1] = ld;
            m_idx_prev = m_filt[2];
            for (int j = 0; j < 3; j++) begin
                syn = (m_dn[j] == S) ? m_dly[j][0] : 1'b0;
                for (int k = 0; k < S - 1; k++) m_dly[j][k] = m_dly[j][k+1];
                m_dly[j][S-1] = raw[j];
                if (m_dn[j] < S) m_dn[j]++;
                for (int k = 0; k < F - 1; k++) m_win[j][k] = m_win[j][k+1];
                m_win[j][F-1] = syn;
                if (m_wn[j] < F) m_wn[j]++;
                all_new = (m_wn[j] == F);
                for (int k = 0; k < F; k++) if (m_win[j][k] == m_filt[j]) all_new = 1'b0;
                if (all_new) m_filt[j] = ~m_filt[j];
            end
        end
        #1;
        since_change++;
        if (reset) pos_dut = 0;
        else if (bus.load === 1'b1) pos_dut = 0;
        else if (bus.enable === 1'b1) pos_dut = (pos_dut + (bus.upCount === 1'b1 ? 1 : 15)) % 16;
        if (bus.enable === 1'b1) begin
            cnt_en++; last_lat = since_change;
            if (bus.upCount === 1'b1) cnt_up++; else cnt_dn++;
        end
        if (bus.load === 1'b1) cnt_load++;
        if (bus.errorTick === 1'b1) cnt_err++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (outs() !== 4'b0000) begin
                fails++; $display("[TB] FAIL reset_outputs cyc=%0d got=%b exp=0000", c, outs());
            end
        end
        checks++;
        if (bus.loadValue !== 4'd0) begin
            fails++; $display("[TB] FAIL reset_loadValue got=%0d exp=0", bus.loadValue);
        end
        reset = 1'b0;
        clear_counts();
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (outs() !== exp_out) begin
                fails++; $display("[TB] FAIL reset_idle cyc=%0d got=%b exp=%b", c, outs(), exp_out);
            end
        end
    endtask

    task automatic test_forward();
        bit [1:0] seq [5] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
        int exp_en;
        for (int s = 0; s < 5; s++) begin
            clear_counts();
            drive(seq[s][1], seq[s][0], 1'b0);
            for (int c = 0; c < 8; c++) begin
                tick();
                checks++;
                if (outs() !== exp_out) begin
                    fails++; $display("[TB] FAIL fwd_cycle step=%0d cyc=%0d got=%b exp=%b", s, c, outs(), exp_out);
                end
            end
            exp_en = (s == 0) ? 0 : ((X4 || seq[s] == 2'b00) ? 1 : 0);
            checks++;
            if (cnt_en !== exp_en || cnt_up !== exp_en || cnt_err !== 0) begin
                fails++; $display("[TB] FAIL fwd_strobes step=%0d got en=%0d up=%0d err=%0d exp en=%0d up=%0d err=0", s, cnt_en, cnt_up, cnt_err, exp_en, exp_en);
            end
            if (exp_en == 1) begin
                checks++;
                if (last_lat !== 7) begin
                    fails++; $display("[TB] FAIL fwd_latency step=%0d got=%0d exp=7", s, last_lat);
                end
            end
        end
        checks++;
        if (pos_dut !== (X4 ? 4 : 1)) begin
            fails++; $display("[TB] FAIL fwd_position got=%0d exp=%0d", pos_dut, X4 ? 4 : 1);
        end
    endtask

    task automatic test_reverse();
        bit [1:0] seq [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        int exp_en;
        for (int s = 0; s < 5; s++) begin
            clear_counts();
            drive(seq[s][1], seq[s][0], 1'b0);
            for (int c = 0; c < 8; c++) begin
                tick();
                checks++;
                if (outs() !== exp_out) begin
                    fails++; $display("[TB] FAIL rev_cycle step=%0d cyc=%0d got=%b exp=%b", s, c, outs(), exp_out);
                end
            end
            exp_en = (X4 || seq[s] == 2'b01) ? 1 : 0;
            checks++;
            if (cnt_en !== exp_en || cnt_dn !== exp_en) begin
                fails++; $display("[TB] FAIL rev_strobes step=%0d got en=%0d dn=%0d exp=%0d", s, cnt_en, cnt_dn, exp_en);
            end
        end
        checks++;
        if (pos_dut !== (X4 ? 15 : 0)) begin
            fails++; $display("[TB] FAIL rev_position got=%0d exp=%0d", pos_dut, X4 ? 15 : 0);
        end
    endtask

    task automatic test_glitch();
        phase_t ph [5] = '{'{0, 1, 0, 2}, '{0, 0, 0, 10}, '{0, 1, 0, 3}, '{0, 0, 0, 10}, '{0, 1, 0, 12}};
        clear_counts();
        for (int p = 0; p < 5; p++) begin
            if (p == 4) begin
                checks++;
                if (cnt_en !== 0 || cnt_err !== 0) begin
                    fails++; $display("[TB] FAIL glitch_rejected got en=%0d err=%0d exp 0", cnt_en, cnt_err);
                end
                clear_counts();
            end
            drive(ph[p].a, ph[p].b, ph[p].i);
            for (int c = 0; c < ph[p].hold; c++) begin
                tick();
                checks++;
                if (outs() !== exp_out) begin
                    fails++; $display("[TB] FAIL glitch_cycle ph=%0d cyc=%0d got=%b exp=%b", p, c, outs(), exp_out);
                end
            end
        end
        checks++;
        if (cnt_en !== 1 || cnt_dn !== 1) begin
            fails++; $display("[TB] FAIL glitch_accepted got en=%0d dn=%0d exp 1", cnt_en, cnt_dn);
        end
    endtask

    task automatic test_error();
        phase_t ph [4] = '{'{0, 0, 0, 10}, '{1, 1, 0, 10}, '{0, 1, 0, 10}, '{0, 0, 0, 10}};
        int pos_before;
        for (int p = 0; p < 4; p++) begin
            if (p == 1) begin clear_counts(); pos_before = pos_dut; end
            if (p == 2) begin
                checks++;
                if (cnt_err !== 1 || cnt_en !== 0 || pos_dut !== pos_before) begin
                    fails++; $display("[TB] FAIL error_jump got err=%0d en=%0d pos=%0d exp err=1 en=0 pos=%0d", cnt_err, cnt_en, pos_dut, pos_before);
                end
                clear_counts();
            end
            drive(ph[p].a, ph[p].b, ph[p].i);
            for (int c = 0; c < ph[p].hold; c++) begin
                tick();
                checks++;
                if (outs() !== exp_out) begin
                    fails++; $display("[TB] FAIL error_cycle ph=%0d cyc=%0d got=%b exp=%b", p, c, outs(), exp_out);
                end
            end
        end
        checks++;
        if (cnt_en !== (X4 ? 2 : 1) || cnt_up !== cnt_en || cnt_err !== 0) begin
            fails++; $display("[TB] FAIL error_recover got en=%0d up=%0d err=%0d exp en=%0d", cnt_en, cnt_up, cnt_err, X4 ? 2 : 1);
        end
    endtask

    task automatic test_index();
        phase_t ph [4] = '{'{0, 0, 1, 6}, '{0, 0, 0, 10}, '{0, 1, 1, 10}, '{0, 1, 0, 10}};
        clear_counts();
        for (int p = 0; p < 4; p++) begin
            if (p == 2) begin
                checks++;
                if (cnt_load !== 1 || pos_dut !== 0 || bus.loadValue !== 4'd0) begin
                    fails++; $display("[TB] FAIL index_load got load=%0d pos=%0d lv=%0d exp 1,0,0", cnt_load, pos_dut, bus.loadValue);
                end
                clear_counts();
            end
            drive(ph[p].a, ph[p].b, ph[p].i);
            for (int c = 0; c < ph[p].hold; c++) begin
                tick();
                checks++;
                if (outs() !== exp_out) begin
                    fails++; $display("[TB] FAIL index_cycle ph=%0d cyc=%0d got=%b exp=%b", p, c, outs(), exp_out);
                end
            end
        end
        checks++;
        if (cnt_load !== 1 || cnt_en !== 0 || pos_dut !== 0) begin
            fails++; $display("[TB] FAIL index_with_step got load=%0d en=%0d pos=%0d exp 1,0,0", cnt_load, cnt_en, pos_dut);
        end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        drive(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (outs() !== exp_out) begin
                fails++; $display("[TB] FAIL rstmid_pre cyc=%0d got=%b exp=%b", c, outs(), exp_out);
            end
        end
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (outs() !== 4'b0000) begin
                fails++; $display("[TB] FAIL rstmid_abort cyc=%0d got=%b exp=0000", c, outs());
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if (outs() !== 4'b0000) begin
            fails++; $display("[TB] FAIL rstmid_after got=%b exp=0000", outs());
        end
        drive(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (outs() !== exp_out) begin
                fails++; $display("[TB] FAIL rstmid_prime cyc=%0d got=%b exp=%b", c, outs(), exp_out);
            end
        end
        checks++;
        if (cnt_en !== 0 || cnt_err !== 0) begin
            fails++; $display("[TB] FAIL rstmid_prime_only got en=%0d err=%0d exp 0", cnt_en, cnt_err);
        end
        drive(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (outs() !== exp_out) begin
                fails++; $display("[TB] FAIL rstmid_step cyc=%0d got=%b exp=%b", c, outs(), exp_out);
            end
        end
        checks++;
        if (cnt_en !== 1 || cnt_up !== 1) begin
            fails++; $display("[TB] FAIL rstmid_first_step got en=%0d up=%0d exp 1", cnt_en, cnt_up);
        end
    endtask

    task automatic test_random();
        int mode;
        int hold;
        bit [1:0] ab;
        bit idx;
        for (int it = 0; it < 300; it++) begin
            ab   = {chA, chB};
            idx  = index;
            mode = $urandom_range(0, 9);
            if (mode <= 5) ab = (mode % 2 == 0) ? {~ab[0], ab[1]} : {ab[0], ~ab[1]};
            else if (mode == 6) ab = ~ab;
            else if (mode == 7) idx = ~idx;
            else if (mode == 8) begin idx = ~idx; ab = {ab[1], ~ab[0]}; end
            reset = ($urandom_range(0, 39) == 0);
            drive(ab[1], ab[0], idx);
            hold = $urandom_range(1, 12);
            for (int c = 0; c < hold; c++) begin
                tick();
                if (c == 1) reset = 1'b0;
                checks++;
                if (outs() !== exp_out) begin
                    fails++; $display("[TB] FAIL random it=%0d cyc=%0d got=%b exp=%b", it, c, outs(), exp_out);
                end
            end
            reset = 1'b0;
        end
    endtask

    // Guard against a stalled simulation
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Scenario sequence
    initial begin
        since_change = 0;
        pos_dut      = 0;
        clear_counts();
        test_reset();
        test_forward();
        test_reverse();
        test_glitch();
        test_error();
        test_index();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
